// File: rtl/conv_result_collector.sv
// Result-write receiver for the convolution engine: buffers indexed result words
// (last write wins) and streams the finished vector out over valid/ready on completion.
module conv_result_collector #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              done_i,
    input  logic [ADDR_W:0]   size_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              drain_done_o,
    output logic              err_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] DRAIN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DEPTH-1:0]  mask_q, mask_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              drain_done_q, drain_done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] word_view [DEPTH];
    logic              wr_commit;
    logic [ADDR_W:0]   size_clip;
    logic [ADDR_W-1:0] nxt_idx;
    logic [DATA_W-1:0] first_word;

    // Writes are only honoured while collecting; in DRAIN they only raise err.
    assign wr_commit = (state_q == COLLECT) && wr_i;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Entries never written since the last drain read back as zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            assign word_view[gi] = mask_q[gi] ? mem_q[gi] : '0;
        end
    endgenerate

    assign size_clip = (size_i > DEPTH_W) ? DEPTH_W : size_i;
    assign nxt_idx   = rd_ptr_q[ADDR_W-1:0] + ADDR_W'(1);
    // A write landing on index 0 in the done cycle must appear in the first word.
    assign first_word = (wr_commit && (wr_addr_i == '0)) ? wr_data_i : word_view[0];

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        rd_ptr_d     = rd_ptr_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        busy_d       = busy_q;
        drain_done_d = 1'b0;
        err_d        = err_q;

        case (state_q)
            COLLECT: begin
                if (wr_commit) begin
                    mask_d[wr_addr_i] = 1'b1;
                end
                if (done_i) begin
                    cnt_d    = size_clip;
                    rd_ptr_d = '0;
                    if (size_i > DEPTH_W) begin
                        err_d = 1'b1;
                    end
                    if (size_clip == '0) begin
                        drain_done_d = 1'b1;
                        mask_d       = '0;
                    end else begin
                        state_d     = DRAIN;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        out_data_d  = first_word;
                        out_last_d  = (size_clip == (ADDR_W + 1)'(1));
                    end
                end
            end
            DRAIN: begin
                if (wr_i || done_i) begin
                    err_d = 1'b1;
                end
                if (out_valid_q && out_ready_i) begin
                    if (out_last_q) begin
                        state_d      = COLLECT;
                        mask_d       = '0;
                        rd_ptr_d     = '0;
                        out_data_d   = '0;
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        busy_d       = 1'b0;
                        drain_done_d = 1'b1;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + (ADDR_W + 1)'(1);
                        out_data_d = word_view[nxt_idx];
                        out_last_d = (rd_ptr_q + (ADDR_W + 1)'(2)) == cnt_q;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= COLLECT;
            mask_q       <= '0;
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            drain_done_q <= drain_done_d;
            err_q        <= err_d;
        end
    end

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_last_q;
    assign busy_o       = busy_q;
    assign drain_done_o = drain_done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Self-checking bench for conv_result_collector: directed scenarios plus randomized
// vectors checked against an index-addressed result model.
module tb_conv_result_collector;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              wr_i = 1'b0;
    logic [ADDR_W-1:0] wr_addr_i = '0;
    logic [DATA_W-1:0] wr_data_i = '0;
    logic              done_i = 1'b0;
    logic [ADDR_W:0]   size_i = '0;
    logic [DATA_W-1:0] out_data_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic              out_last_o;
    logic              busy_o;
    logic              drain_done_o;
    logic              err_o;

    conv_result_collector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .wr_i(wr_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .done_i(done_i), .size_i(size_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_last_o(out_last_o), .busy_o(busy_o),
        .drain_done_o(drain_done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Reference model: value per index, written flag per index, sticky error.
    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                model_mask [DEPTH];
    bit                model_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Capture results of one drain
    logic [DATA_W-1:0] got_q [$];
    bit                got_last_q [$];
    bit                rdy_pat [$];
    int                n_cycles, stall_bad, dd_early;
    bit                timed_out, first_valid;
    int                inj_c = -1;
    logic [ADDR_W-1:0] inj_addr = '0;
    logic [DATA_W-1:0] inj_data = '0;

    function automatic logic [DATA_W-1:0] exp_word(int i);
        return model_mask[i] ? model_mem[i] : '0;
    endfunction

    task automatic clear_model_mask();
        for (int i = 0; i < DEPTH; i++) model_mask[i] = 0;
    endtask

    task automatic do_write(input int addr, input logic [DATA_W-1:0] data);
        wr_i = 1'b1; wr_addr_i = ADDR_W'(addr); wr_data_i = data;
        @(negedge clk);
        wr_i = 1'b0;
        model_mem[addr] = data;
        model_mask[addr] = 1;
    endtask

    task automatic do_done(input int size);
        done_i = 1'b1; size_i = (ADDR_W + 1)'(size);
        @(negedge clk);
        done_i = 1'b0;
        if (size > DEPTH) model_err = 1;
    endtask

    // Drives ready from rdy_pat (then 1) and records every handshaken word.
    // Returns at the negedge following the final handshake.
    task automatic collect(input int max_c);
        bit held;
        logic [DATA_W-1:0] held_data;
        bit held_last;
        got_q.delete(); got_last_q.delete();
        stall_bad = 0; dd_early = 0; timed_out = 1; held = 0; n_cycles = 0;
        held_data = '0; held_last = 0;
        first_valid = out_valid_o;
        for (int c = 0; c < max_c; c++) begin
            out_ready_i = (c < rdy_pat.size()) ? rdy_pat[c] : 1'b1;
            wr_i = (c == inj_c); wr_addr_i = inj_addr; wr_data_i = inj_data;
            if (drain_done_o) dd_early++;
            if (out_valid_o) begin
                if (held && (out_data_o !== held_data || out_last_o !== held_last)) stall_bad++;
                held = !out_ready_i; held_data = out_data_o; held_last = out_last_o;
                if (out_ready_i) begin
                    got_q.push_back(out_data_o);
                    got_last_q.push_back(out_last_o);
                    if (out_last_o) begin
                        n_cycles = c + 1; timed_out = 0;
                        @(negedge clk);
                        break;
                    end
                end
            end
            @(negedge clk);
        end
        wr_i = 1'b0; out_ready_i = 1'b0; inj_c = -1; rdy_pat.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_data_o, out_valid_o, out_last_o, busy_o, drain_done_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%h v=%b l=%b busy=%b dd=%b err=%b, want all 0",
                     out_data_o, out_valid_o, out_last_o, busy_o, drain_done_o, err_o);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset: v=%b busy=%b, want 0 0", out_valid_o, busy_o);
        end
    endtask

    task automatic test_basic();
        do_write(0, 10); do_write(1, 20); do_write(2, 30); do_write(3, 40);
        do_done(4);
        n_cmp++;
        if (busy_o !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy_o); end
        collect(50);
        n_cmp++;
        if (timed_out || first_valid !== 1'b1 || n_cycles != 4) begin
            n_bad++; $display("FAIL basic_timing: to=%0d first_valid=%b cycles=%0d want 0 1 4", timed_out, first_valid, n_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= got_q.size() || got_q[i] !== 32'((i + 1) * 10) || got_last_q[i] !== (i == 3)) begin
                n_bad++; $display("FAIL basic_word%0d: got %0d last %b want %0d last %b", i,
                                  (i < got_q.size()) ? got_q[i] : 'x, (i < got_q.size()) ? got_last_q[i] : 1'bx, (i + 1) * 10, i == 3);
            end
        end
        n_cmp++;
        if (drain_done_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0 || dd_early != 0) begin
            n_bad++; $display("FAIL basic_done: dd=%b busy=%b v=%b early=%0d want 1 0 0 0", drain_done_o, busy_o, out_valid_o, dd_early);
        end
        clear_model_mask();
        @(negedge clk);
        n_cmp++;
        if (drain_done_o !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", drain_done_o); end
    endtask

    task automatic test_overwrite_holes();
        do_write(1, 5); do_write(1, 9);
        do_done(3);
        collect(50);
        n_cmp++;
        if (timed_out || got_q.size() != 3 || got_q[0] !== 0 || got_q[1] !== 9 || got_q[2] !== 0) begin
            n_bad++; $display("FAIL overwrite_stream: got %p want '{0,9,0}", got_q);
        end
        clear_model_mask();
        do_write(2, 33);
        do_done(3);
        collect(50);
        n_cmp++;
        if (timed_out || got_q.size() != 3 || got_q[0] !== 0 || got_q[1] !== 0 || got_q[2] !== 33) begin
            n_bad++; $display("FAIL stale_stream: got %p want '{0,0,33}", got_q);
        end
        clear_model_mask();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] w [3];
        for (int i = 0; i < 3; i++) begin w[i] = $urandom; do_write(i, w[i]); end
        do_done(3);
        rdy_pat = '{1, 0, 0, 1, 1};
        collect(50);
        n_cmp++;
        if (timed_out || got_q.size() != 3 || got_q[0] !== w[0] || got_q[1] !== w[1] || got_q[2] !== w[2]) begin
            n_bad++; $display("FAIL bp_stream: got %p want '{%h,%h,%h}", got_q, w[0], w[1], w[2]);
        end
        n_cmp++;
        if (stall_bad != 0 || n_cycles != 5) begin
            n_bad++; $display("FAIL bp_stall: unstable=%0d cycles=%0d want 0 5", stall_bad, n_cycles);
        end
        n_cmp++;
        if (drain_done_o !== 1'b1 || dd_early != 0) begin
            n_bad++; $display("FAIL bp_done: dd=%b early=%0d want 1 0", drain_done_o, dd_early);
        end
        clear_model_mask();
    endtask

    task automatic test_simultaneous();
        wr_i = 1'b1; wr_addr_i = 2; wr_data_i = 77; done_i = 1'b1; size_i = 3;
        @(negedge clk);
        wr_i = 1'b0; done_i = 1'b0;
        collect(50);
        n_cmp++;
        if (timed_out || got_q.size() != 3 || got_q[0] !== 0 || got_q[1] !== 0 || got_q[2] !== 77) begin
            n_bad++; $display("FAIL simul_stream: got %p want '{0,0,77}", got_q);
        end
        clear_model_mask();
    endtask

    task automatic test_size_zero();
        do_write(0, 55);
        do_done(0);
        n_cmp++;
        if (drain_done_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL zero_done: dd=%b v=%b busy=%b want 1 0 0", drain_done_o, out_valid_o, busy_o);
        end
        clear_model_mask();
        @(negedge clk);
        n_cmp++;
        if (drain_done_o !== 1'b0 || out_valid_o !== 1'b0 || err_o !== 1'b0) begin
            n_bad++; $display("FAIL zero_after: dd=%b v=%b err=%b want 0 0 0", drain_done_o, out_valid_o, err_o);
        end
        do_done(1);
        collect(20);
        n_cmp++;
        if (timed_out || got_q.size() != 1 || got_q[0] !== 0) begin
            n_bad++; $display("FAIL zero_mask_cleared: got %p want '{0}", got_q);
        end
        clear_model_mask();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int k, n, bad;
            k = $urandom_range(1, 40);
            for (int j = 0; j < k; j++) do_write($urandom_range(0, DEPTH - 1), $urandom);
            n = $urandom_range(1, DEPTH);
            for (int j = 0; j < 120; j++) rdy_pat.push_back($urandom_range(0, 3) != 0);
            do_done(n);
            collect(400);
            bad = 0;
            if (timed_out || got_q.size() != n) bad++;
            for (int i = 0; i < got_q.size() && i < n; i++)
                if (got_q[i] !== exp_word(i) || got_last_q[i] !== (i == n - 1)) bad++;
            n_cmp++;
            if (bad != 0 || stall_bad != 0 || drain_done_o !== 1'b1 || dd_early != 0) begin
                n_bad++; $display("FAIL random_vec%0d: n=%0d got %0d words, %0d word errors, unstable=%0d dd=%b",
                                  it, n, got_q.size(), bad, stall_bad, drain_done_o);
            end
            clear_model_mask();
        end
    endtask

    task automatic test_wr_in_drain();
        logic [DATA_W-1:0] w [4];
        for (int i = 0; i < 4; i++) begin w[i] = $urandom; do_write(i, w[i]); end
        do_done(4);
        inj_c = 1; inj_addr = 3; inj_data = 32'hdead_beef;
        collect(50);
        model_err = 1;
        n_cmp++;
        if (timed_out || got_q.size() != 4 || got_q[0] !== w[0] || got_q[1] !== w[1] || got_q[2] !== w[2] || got_q[3] !== w[3]) begin
            n_bad++; $display("FAIL drain_wr_stream: got %p want '{%h,%h,%h,%h}", got_q, w[0], w[1], w[2], w[3]);
        end
        n_cmp++;
        if (err_o !== model_err) begin n_bad++; $display("FAIL drain_wr_err: got %b want %b", err_o, model_err); end
        clear_model_mask();
    endtask

    task automatic test_reset_mid_drain();
        do_write(0, 7); do_write(1, 8);
        do_done(4);
        out_ready_i = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({out_data_o, out_valid_o, out_last_o, busy_o, drain_done_o, err_o} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got data=%h v=%b l=%b busy=%b dd=%b err=%b, want all 0",
                     out_data_o, out_valid_o, out_last_o, busy_o, drain_done_o, err_o);
        end
        out_ready_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        clear_model_mask(); model_err = 0;
        @(negedge clk);
        n_cmp++;
        if (drain_done_o !== 1'b0 || out_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL midreset_nopulse: dd=%b v=%b want 0 0", drain_done_o, out_valid_o);
        end
        do_done(2);
        collect(20);
        n_cmp++;
        if (timed_out || got_q.size() != 2 || got_q[0] !== 0 || got_q[1] !== 0) begin
            n_bad++; $display("FAIL midreset_stream: got %p want '{0,0}", got_q);
        end
        clear_model_mask();
    endtask

    task automatic test_oversize();
        int bad;
        for (int i = 0; i < DEPTH; i++) do_write(i, $urandom);
        n_cmp++;
        if (err_o !== 1'b0) begin n_bad++; $display("FAIL oversize_pre_err: got %b want 0", err_o); end
        do_done(40);
        n_cmp++;
        if (err_o !== model_err) begin n_bad++; $display("FAIL oversize_err: got %b want %b", err_o, model_err); end
        collect(200);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < DEPTH; i++)
            if (got_q[i] !== exp_word(i) || got_last_q[i] !== (i == DEPTH - 1)) bad++;
        n_cmp++;
        if (timed_out || got_q.size() != DEPTH || bad != 0 || n_cycles != DEPTH) begin
            n_bad++; $display("FAIL oversize_stream: got %0d words in %0d cycles, %0d word errors, want 32 in 32",
                              got_q.size(), n_cycles, bad);
        end
        clear_model_mask();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin model_mem[i] = '0; model_mask[i] = 0; end
        model_err = 0;
        test_reset();
        test_basic();
        test_overwrite_holes();
        test_backpressure();
        test_simultaneous();
        test_size_zero();
        test_random();
        test_wr_in_drain();
        test_reset_mid_drain();
        test_oversize();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/conv_result_collector.md
# conv_result_collector

Receiving end of the convolution engine's result-write interface. Captures every result write strobe into a per-index result buffer, with the last write to an index winning. When the engine signals completion, it streams the finished result vector to the host side over a valid/ready handshake. It sits between the convolution datapath and the SoC output path (bus slave / UART bridge).

## Interface
- DATA_W, 32, result word width
- ADDR_W, 5, result index width; DEPTH = 2**ADDR_W entries

- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low
- wr_i  in  1  engine write strobe; one result per cycle when high
- wr_addr_i  in  ADDR_W  result index i of the write
- wr_data_i  in  DATA_W  result value temp_z
- done_i  in  1  engine completion pulse (single cycle)
- size_i  in  ADDR_W+1  number of results (sizeZ); sampled on done_i
- out_data_o  out  DATA_W  streamed result word
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  downstream accepts word when high with out_valid_o
- out_last_o  out  1  high with the final word of the vector
- busy_o  out  1  high while draining
- drain_done_o  out  1  one-cycle pulse after vector fully delivered
- err_o  out  1  sticky protocol error flag

## Operation
- Storage: DEPTH x DATA_W flop array plus DEPTH-bit written mask. Unwritten entries read out as 0.
- States: COLLECT (reset state), DRAIN.
- COLLECT:
  - wr_i=1 stores wr_data_i at wr_addr_i and sets mask[wr_addr_i].
  - Repeated writes to the same index overwrite the entry; the last one wins.
- done_i in COLLECT:
  - Latch cnt = min(size_i, DEPTH) and set rd_ptr = 0.
  - If size_i > DEPTH, set err_o and use cnt = DEPTH.
  - If cnt = 0, stay in COLLECT, pulse drain_done_o next cycle, and clear the mask.
  - Otherwise go to DRAIN.
- wr_i and done_i in the same cycle: the write is committed and is visible in the drained vector.
- DRAIN:
  - out_data_o = mask[rd_ptr] ? mem[rd_ptr] : 0.
  - out_last_o = (rd_ptr == cnt-1).
  - On out_valid_o & out_ready_i, rd_ptr increments and the next word is presented in the next cycle.
  - Data and last are held stable while out_valid_o & !out_ready_i.
- Last word handshake: clear the mask, drop out_valid_o, pulse drain_done_o, and return to COLLECT.
- wr_i or done_i in DRAIN: ignored, and err_o is set.
- err_o clears only on reset.
- rd_ptr is ADDR_W+1 bits; no wrap occurs because the drain ends at cnt-1.

## Timing
- Reset values:
  - out_data_o = 0, out_valid_o = 0, out_last_o = 0
  - busy_o = 0, drain_done_o = 0, err_o = 0
  - state = COLLECT, mask = 0, rd_ptr = 0, cnt = 0
- All outputs are registered.
- Write strobe at edge t: data is readable from t+1.
- done_i sampled at edge t:
  - busy_o and out_valid_o are high in cycle t+1.
  - The first word (index 0) is on out_data_o in cycle t+1.
- Throughput: one word per cycle with out_ready_i held high.
- A cnt-word vector with ready always high occupies cycles t+1..t+cnt.
- drain_done_o is high in cycle t+cnt+1, together with busy_o=0 and out_valid_o=0.
- New writes are accepted from cycle t+cnt+1.
- Back-pressure: each low cycle of out_ready_i stretches the drain by one cycle. No word is skipped or duplicated.
- rstn asserted mid-drain: outputs go immediately to reset values, the mask is cleared, and no drain_done_o pulse is generated.

## Test plan
- Basic vector: write idx0..3 = 10,20,30,40, then done_i with size 4 and ready high.
  - Required: words 10,20,30,40 on 4 consecutive cycles starting 1 cycle after done_i.
  - Required: last on the 4th word; drain_done_o one cycle later.
- Overwrite and holes: write idx1=5, then idx1=9, leave idx0 and idx2 unwritten, done_i with size 3.
  - Required: stream 0,9,0.
  - Run a second vector and check that no stale data appears.
- Back-pressure: 3-word vector with out_ready_i pattern 1,0,0,1,1.
  - Required: words delivered in order with data held stable during the stalls.
  - Required: drain_done_o exactly one cycle after the third handshake.
- Simultaneous and error events:
  - wr_i(idx2=77) in the same cycle as done_i(size 3): required drain 0,0,77.
  - wr_i during DRAIN: required err_o=1 and the stream is unchanged.
  - size_i=40 with DEPTH=32: required err_o=1 and a 32-word drain.
- Size zero: done_i with size_i=0.
  - Required: out_valid_o never rises, drain_done_o pulses the next cycle, and err_o stays 0.
- Reset mid-drain: assert rstn low in the 2nd drain word.
  - Required: all outputs 0 immediately.
  - Required: a subsequent done_i with size 2 streams 0,0.
